tc_rr_arb: RTL and testbench
============================

# tc_rr_arb

Round-robin arbiter with transfer quota and bus watchdog for the traffic cop's single-target ports. It takes per-initiator request lines (cycle qualified by address decode), grants one of 8 initiators, and drives the select of an external initiator/target mux. It preempts an initiator that exceeds its transfer quota while others wait. It also terminates stalled strobes with a synthesized error.

## Interface
Parameters:
- QUOTA, 8: max completed transfers per tenure before preemption when others are waiting; 0 disables preemption.
- TMO_W, 8: watchdog counter width.
- TMO_MAX, 255: stalled-strobe cycles before watchdog error; must be ≥1 and < 2^TMO_W.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  8  per-initiator request; bit k = initiator k cyc & address hit.
- stb_i  in  1  strobe of the currently granted initiator, muxed externally.
- ack_i  in  1  target acknowledge.
- err_i  in  1  target error.
- tmo_clr_i  in  1  clears tmo_sts_o.
- gnt_o  out  3  index of the granted, or last granted, initiator.
- gnt_vld_o  out  1  grant valid; the mux routes gnt_o only while high.
- tmo_err_o  out  1  one-cycle synthesized error to the granted initiator.
- tmo_sts_o  out  8  sticky watchdog-expiry flag per initiator.

## Operation
- States: IDLE, GRANT.
- Reset (wb_rst_ni low at an edge):
  - state IDLE, gnt_o=3'd7, gnt_vld_o=0, tmo_err_o=0, tmo_sts_o=0, transfer and watchdog counters 0.
  - Applies mid-tenure; the grant drops at that edge.
- IDLE:
  - gnt_vld_o=0.
  - If req_i≠0, select the first set bit searching gnt_o+1, gnt_o+2, … mod 8. Load it into gnt_o, clear the transfer counter, enter GRANT.
  - With the reset value gnt_o=7, initiator 0 wins first.
- GRANT:
  - gnt_vld_o=1.
  - A completion is ack_i|err_i|tmo_err_o while stb_i=1. Each completion increments the transfer counter, which saturates at QUOTA.
- GRANT exit conditions:
  - req_i[gnt_o]=0: go to IDLE.
  - Quota preemption: QUOTA≠0, a completion brings the count to QUOTA or it is already QUOTA, and (req_i & ~onehot(gnt_o))≠0. Go to IDLE after that completion cycle.
  - With no other requester, the tenure continues and quota is re-checked at each completion.
- Every tenure ends with at least one IDLE cycle; there are no back-to-back grants.
- Watchdog, in GRANT only:
  - Counter increments each cycle with stb_i=1 and ack_i=err_i=0.
  - Counter clears on ack_i, err_i, stb_i=0, or leaving GRANT.
  - When the count reaches TMO_MAX, tmo_err_o=1 for the next cycle, the counter clears, and tmo_sts_o[gnt_o] is set.
- Simultaneous events:
  - ack_i/err_i in the expiry cycle suppresses tmo_err_o.
  - tmo_clr_i together with a new set: the set wins for that bit; other bits clear.
  - req_i[gnt_o] dropping in the same cycle as a quota completion: go to IDLE, with a single exit.

## Timing
- Grant latency: req_i rises in cycle n from IDLE → gnt_vld_o=1 in cycle n+1.
- Release: req_i[gnt_o] low in cycle n → gnt_vld_o=0 in cycle n+1 → earliest next grant in cycle n+2.
- gnt_o changes only on the IDLE→GRANT edge and is stable throughout GRANT.
- tmo_err_o is registered; it is high exactly TMO_MAX+1 cycles after stb_i rises with no ack.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- TC_ARB_TMO_EN defined:
  - Watchdog counter, tmo_err_o and tmo_sts_o are implemented as above.
- TC_ARB_TMO_EN undefined:
  - Watchdog logic is absent and tmo_err_o and tmo_sts_o are tied to 0.
  - tmo_clr_i is ignored.
  - Completions are ack_i|err_i only.
  - All other behaviour is identical.

## Test plan
- Reset, then req_i=8'hFF held → grants 0,1,2,…,7,0 in order, each tenure separated by one IDLE cycle. With QUOTA=8 and ack_i every cycle under stb_i, each tenure lasts 8 acks.
- req_i=8'h01 alone with 20 acks → no preemption and gnt_o=0 throughout. Raise req_i[3] after ack 20 → next completion ends the tenure and gnt_o=3 two cycles later.
- gnt_o=5, req_i[5] drops while req_i[2] is set → IDLE one cycle, then gnt_o=2, not 6 or 7 unless they are requesting.
- TC_ARB_TMO_EN, TMO_MAX=4, stb_i high with no ack → tmo_err_o pulses 5 cycles after stb_i rises and tmo_sts_o[gnt_o]=1. Assert tmo_clr_i → flag cleared next cycle.
- Expiry cycle coinciding with ack_i → no tmo_err_o and flag stays 0. tmo_clr_i coinciding with a new set → bit remains 1.
- wb_rst_ni low for one cycle mid-tenure → gnt_vld_o=0, gnt_o=7 and counters cleared next cycle. With req_i=8'h81 afterwards → initiator 0 granted first.

Source files
------------

// File: rtl/tc_rr_arb.sv
// tc_rr_arb: round-robin 8-initiator arbiter with transfer quota preemption; stalled-strobe watchdog under TC_ARB_TMO_EN
module tc_rr_arb #(
  parameter int QUOTA   = 8,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic [7:0] req_i,
  input  logic       stb_i,
  input  logic       ack_i,
  input  logic       err_i,
  input  logic       tmo_clr_i,
  output logic [2:0] gnt_o,
  output logic       gnt_vld_o,
  output logic       tmo_err_o,
  output logic [7:0] tmo_sts_o
);
  localparam int CW = QUOTA > 0 ? $clog2(QUOTA + 1) : 1;
  localparam logic [CW-1:0] QMAX = CW'(QUOTA);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [2:0] gnt_q, gnt_d, sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cmp, others, preempt;
  logic tmo_err_q;
  logic [7:0] tmo_sts_q;
  always_comb begin
    sel = gnt_q;
    for (int i = 8; i >= 1; i--) if (req_i[gnt_q + 3'(i)]) sel = gnt_q + 3'(i);
    cmp = stb_i && (ack_i || err_i || tmo_err_q);
    others = |(req_i & ~(8'(1) << gnt_q));
    preempt = QUOTA != 0 && cmp && others && (cnt_q == QMAX || cnt_q == QMAX - 1'b1);
    state_d = state_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (|req_i) begin
        state_d = GRANT;
        gnt_d = sel;
        cnt_d = '0;
      end
    end else begin
      if (cmp && cnt_q != QMAX) cnt_d = cnt_q + 1'b1;
      if (!req_i[gnt_q] || preempt) state_d = IDLE;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      gnt_q <= 3'd7;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef TC_ARB_TMO_EN
  logic [TMO_W-1:0] wd_q, wd_d;
  logic tmo_err_d, expire;
  logic [7:0] tmo_sts_d;
  // an ack or error in the expiry cycle means the target answered in time
  always_comb begin
    expire = state_q == GRANT && stb_i && !ack_i && !err_i && wd_q == TMO_W'(TMO_MAX);
    wd_d = (state_q != GRANT || state_d != GRANT || !stb_i || ack_i || err_i || expire) ? '0 : wd_q + 1'b1;
    tmo_err_d = expire;
    tmo_sts_d = (tmo_clr_i ? 8'h00 : tmo_sts_q) | (expire ? 8'(1) << gnt_q : 8'h00);
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wd_q <= '0;
      tmo_err_q <= 1'b0;
      tmo_sts_q <= '0;
    end else begin
      wd_q <= wd_d;
      tmo_err_q <= tmo_err_d;
      tmo_sts_q <= tmo_sts_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^{tmo_clr_i, TMO_W[0], TMO_MAX[0]};
  assign tmo_err_q = 1'b0;
  assign tmo_sts_q = '0;
`endif
  assign gnt_o = gnt_q;
  assign gnt_vld_o = state_q == GRANT;
  assign tmo_err_o = tmo_err_q;
  assign tmo_sts_o = tmo_sts_q;
endmodule

// File: tb/tb_tc_rr_arb.sv
// tb_tc_rr_arb: directed plus randomized checks of tc_rr_arb against a cycle-level behavioural model
module tb_tc_rr_arb;
  localparam int QUOTA = 8, TMO_W = 8, TMO_MAX = 4;
`ifdef TC_ARB_TMO_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic wb_clk_i = 1'b0;
  logic wb_rst_ni, stb_i, ack_i, err_i, tmo_clr_i, gnt_vld_o, tmo_err_o;
  logic [7:0] req_i, tmo_sts_o, rq;
  logic [2:0] gnt_o;
  int checks = 0, errors = 0;
  bit m_vld, m_pulse;
  int m_own, m_xfers, m_stall;
  bit [7:0] m_sts;
  int order[$], len[$];
  bit pv;
  int run;
  always #5 wb_clk_i = ~wb_clk_i;
  tc_rr_arb #(.QUOTA(QUOTA), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .req_i(req_i), .stb_i(stb_i),
    .ack_i(ack_i), .err_i(err_i), .tmo_clr_i(tmo_clr_i), .gnt_o(gnt_o),
    .gnt_vld_o(gnt_vld_o), .tmo_err_o(tmo_err_o), .tmo_sts_o(tmo_sts_o)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock edge of the arbiter, described as tenures, transfer tallies and stall runs
  task automatic model_step(bit rst, bit [7:0] req, bit stb, bit ack, bit err, bit clr);
    bit cmp, leave, exp;
    int nxt;
    if (!rst) begin
      m_vld = 0; m_own = 7; m_xfers = 0; m_stall = 0; m_pulse = 0; m_sts = 0;
      return;
    end
    exp = 0;
    if (!m_vld) begin
      m_pulse = 0;
      m_stall = 0;
      if (req != 0) begin
        nxt = -1;
        for (int k = 1; k <= 8; k++) if (nxt < 0 && req[(m_own + k) % 8]) nxt = (m_own + k) % 8;
        m_own = nxt;
        m_vld = 1;
        m_xfers = 0;
      end
    end else begin
      cmp = stb && (ack || err || m_pulse);
      m_xfers += int'(cmp);
      leave = !req[m_own] || (QUOTA > 0 && cmp && m_xfers >= QUOTA && (req & ~(8'd1 << m_own)) != 0);
      if (TMO && stb && !ack && !err) begin
        if (m_stall == TMO_MAX) begin exp = 1; m_stall = 0; end
        else m_stall++;
      end else m_stall = 0;
      if (leave) begin m_vld = 0; m_stall = 0; end
      m_pulse = exp;
    end
    if (TMO) begin
      if (clr) m_sts = 0;
      if (exp) m_sts[m_own] = 1;
    end
  endtask
  task automatic cyc(bit rst, bit [7:0] req, bit stb, bit ack, bit err, bit clr);
    wb_rst_ni = rst; req_i = req; stb_i = stb; ack_i = ack; err_i = err; tmo_clr_i = clr;
    model_step(rst, req, stb, ack, err, clr);
    @(negedge wb_clk_i);
    check("gnt_vld", gnt_vld_o, m_vld);
    check("gnt", gnt_o, m_own);
    check("tmo_err", tmo_err_o, m_pulse);
    check("tmo_sts", tmo_sts_o, m_sts);
  endtask
  initial begin
    cyc(0, 8'h00, 0, 0, 0, 0);
    check("rst_gnt", gnt_o, 7);
    check("rst_vld", gnt_vld_o, 0);
    pv = 0; run = 0;
    for (int c = 0; c < 81; c++) begin
      cyc(1, 8'hFF, 1, 1, 0, 0);
      if (gnt_vld_o && !pv) order.push_back(int'(gnt_o));
      if (gnt_vld_o) run++;
      else if (pv) begin len.push_back(run); run = 0; end
      pv = gnt_vld_o;
    end
    check("rr_count", order.size(), 9);
    check("len_count", len.size(), 9);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 8);
    for (int i = 0; i < len.size(); i++) check("tenure_len", len[i], 8);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(1, 8'h01, 0, 0, 0, 0);
    repeat (20) cyc(1, 8'h01, 1, 1, 0, 0);
    check("solo_vld", gnt_vld_o, 1);
    check("solo_gnt", gnt_o, 0);
    cyc(1, 8'h09, 1, 1, 0, 0);
    check("quota_exit", gnt_vld_o, 0);
    cyc(1, 8'h09, 0, 0, 0, 0);
    check("quota_next", gnt_o, 3);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(1, 8'h20, 0, 0, 0, 0);
    cyc(1, 8'h20, 1, 1, 0, 0);
    cyc(1, 8'h04, 0, 0, 0, 0);
    check("rel_idle", gnt_vld_o, 0);
    cyc(1, 8'h04, 0, 0, 0, 0);
    check("rel_gnt", gnt_o, 2);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(1, 8'h20, 0, 0, 0, 0);
    cyc(1, 8'h84, 0, 0, 0, 0);
    cyc(1, 8'h84, 0, 0, 0, 0);
    check("rel_gnt7", gnt_o, 7);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(1, 8'h01, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 8'h01, 1, 0, 0, 0);
      check("wd_pulse", tmo_err_o, TMO && k == 5);
    end
    check("wd_sts", tmo_sts_o, TMO ? 8'h01 : 8'h00);
    cyc(1, 8'h01, 0, 0, 0, 1);
    check("wd_clr", tmo_sts_o, 0);
    for (int k = 1; k <= 5; k++) cyc(1, 8'h01, 1, k == 5, 0, 0);
    cyc(1, 8'h01, 0, 0, 0, 0);
    check("wd_ack_err", tmo_err_o, 0);
    check("wd_ack_sts", tmo_sts_o, 0);
    for (int k = 1; k <= 5; k++) cyc(1, 8'h01, 1, 0, 0, k == 5);
    check("wd_clr_set", tmo_sts_o, TMO ? 8'h01 : 8'h00);
    cyc(1, 8'h01, 0, 0, 0, 0);
    cyc(1, 8'h08, 0, 0, 0, 0);
    cyc(1, 8'h08, 0, 0, 0, 0);
    check("pre_rst_gnt", gnt_o, 3);
    cyc(0, 8'h81, 1, 1, 0, 0);
    check("mid_rst_vld", gnt_vld_o, 0);
    check("mid_rst_gnt", gnt_o, 7);
    cyc(1, 8'h81, 0, 0, 0, 0);
    check("post_rst_gnt", gnt_o, 0);
    rq = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) rq = rq ^ (8'd1 << $urandom_range(0, 7));
      cyc($urandom_range(0, 299) != 0, rq, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
